// File: rtl/hex_dump_pkg.sv
// hex_dump_pkg: shared definitions for the hex_dump_tx register dump block.
//   state_t        - dump sequencer states
//   CH_*           - ASCII bytes emitted on the UART stream
//   HEX_ALPHA_OFS  - offset that maps nibble values 10..15 onto 'A'..'F'
package hex_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EMIT,
        SETTLE,
        WAITTX,
        DONE
    } state_t;

    localparam logic [7:0] CH_CR         = 8'h0D;
    localparam logic [7:0] CH_LF         = 8'h0A;
    localparam logic [7:0] CH_R          = 8'h52;
    localparam logic [7:0] CH_EQ         = 8'h3D;
    localparam logic [7:0] CH_0          = 8'h30;
    localparam logic [7:0] HEX_ALPHA_OFS = 8'h37;

endpackage

// File: rtl/hex_dump_tx_nib2ascii.sv
// nib2ascii: combinational 4-bit nibble to uppercase ASCII hex character.
//   nib   in  4  nibble value 0..15
//   ascii out 8  '0'..'9' or 'A'..'F'
module nib2ascii
    import hex_dump_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb begin
        if (nib < 4'd10) begin
            ascii = CH_0 + {4'h0, nib};
        end else begin
            ascii = HEX_ALPHA_OFS + {4'h0, nib};
        end
    end

endmodule

// File: rtl/hex_dump_tx.sv
// hex_dump_tx: after a trigger pulse, reads NWORDS words through a synchronous
// read port and streams each one to a UART as uppercase ASCII hex, MSB nibble
// first, terminated by CR LF.
//
// Optional build macro HEX_DUMP_INDEX_EN: prefixes each line with "R<idx>=",
// where <idx> is the word index as one hex character.
//
// Ports:
//   clk      in   1       system clock
//   rst      in   1       asynchronous reset, active-high
//   trigger  in   1       start pulse, sampled only while idle
//   rd_addr  out  AW      word index being read
//   rd_data  in   WORD_W  word at rd_addr, valid one cycle after rd_addr
//   tx_data  out  8       byte to UART din (holds between strobes)
//   tx_wr    out  1       one-cycle UART write strobe
//   tx_busy  in   1       UART transmitter busy
//   busy     out  1       dump in progress
//   done     out  1       one-cycle pulse after the last LF is accepted
module hex_dump_tx
    import hex_dump_pkg::*;
#(
    parameter int NWORDS = 8,
    parameter int WORD_W = 32,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    output logic [AW-1:0]     rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int ND = WORD_W / 4;
`ifdef HEX_DUMP_INDEX_EN
    localparam int PFX = 3;
`else
    localparam int PFX = 0;
`endif
    localparam int NCHARS = PFX + ND + 2;
    localparam int CW     = $clog2(NCHARS);

    state_t            state, state_n;
    logic [AW-1:0]     word_idx, word_n;
    logic [CW-1:0]     char_idx, char_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [7:0]        tx_data_n;
    logic              tx_wr_n, busy_n, done_n;
    logic [7:0]        data_ascii, cur_char;
    logic              is_data;

    // The word index doubles as the read address; it is parked at 0 when idle.
    assign rd_addr = word_idx;

    // Data nibbles always come from the top of the shift register.
    nib2ascii u_nib_data (
        .nib   (shreg[WORD_W-1 -: 4]),
        .ascii (data_ascii)
    );

`ifdef HEX_DUMP_INDEX_EN
    logic [7:0] idx_ascii;

    nib2ascii u_nib_idx (
        .nib   (4'(word_idx)),
        .ascii (idx_ascii)
    );
`endif

    // Character selected by char_idx: [prefix] data nibbles, CR, LF.
    always_comb begin
        cur_char = data_ascii;
        is_data  = 1'b0;
        if (char_idx < CW'(PFX + ND)) begin
            is_data = 1'b1;
        end else if (char_idx == CW'(PFX + ND)) begin
            cur_char = CH_CR;
        end else begin
            cur_char = CH_LF;
        end
`ifdef HEX_DUMP_INDEX_EN
        if (char_idx == CW'(0)) begin
            cur_char = CH_R;
            is_data  = 1'b0;
        end else if (char_idx == CW'(1)) begin
            cur_char = idx_ascii;
            is_data  = 1'b0;
        end else if (char_idx == CW'(2)) begin
            cur_char = CH_EQ;
            is_data  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_idx <= '0;
            char_idx <= '0;
            shreg    <= '0;
            tx_data  <= '0;
            tx_wr    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            word_idx <= word_n;
            char_idx <= char_n;
            shreg    <= shreg_n;
            tx_data  <= tx_data_n;
            tx_wr    <= tx_wr_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Outputs are registered: each is computed here as the value it will
    // take in the next cycle, so tx_wr is visible during SETTLE and done
    // is visible the cycle after DONE, when busy has already dropped.
    always_comb begin
        state_n   = state;
        word_n    = word_idx;
        char_n    = char_idx;
        shreg_n   = shreg;
        tx_data_n = tx_data;
        tx_wr_n   = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = FETCH;
                    busy_n  = 1'b1;
                    word_n  = '0;
                end
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                shreg_n = rd_data;
                char_n  = '0;
                state_n = EMIT;
            end
            EMIT: begin
                if (!tx_busy) begin
                    tx_data_n = cur_char;
                    tx_wr_n   = 1'b1;
                    if (is_data) begin
                        shreg_n = shreg << 4;
                    end
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                state_n = WAITTX;
            end
            WAITTX: begin
                if (!tx_busy) begin
                    if (char_idx != CW'(NCHARS - 1)) begin
                        char_n  = char_idx + CW'(1);
                        state_n = EMIT;
                    end else if (word_idx != AW'(NWORDS - 1)) begin
                        word_n  = word_idx + AW'(1);
                        state_n = FETCH;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                word_n  = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_dump_tx.sv
// tb_hex_dump_tx: self-checking bench for hex_dump_tx. Two instances share
// clock, reset and trigger: one with NWORDS=1 and one with NWORDS=4, each with
// its own synchronous memory and UART busy model.
module tb_hex_dump_tx;

    localparam int NA = 1;
    localparam int NB = 4;
`ifdef HEX_DUMP_INDEX_EN
    localparam int PFX = 3;
`else
    localparam int PFX = 0;
`endif
    localparam int CH = PFX + 10;

    typedef struct {
        logic [31:0] word0;
        logic [31:0] word1;
        logic [63:0] text;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigger = 1'b0;
    logic [1:0][3:0]  rda;
    logic [1:0][31:0] rdd;
    logic [1:0][7:0]  txd;
    logic [1:0]       txw;
    logic [1:0]       txb;
    logic [1:0]       bsy;
    logic [1:0]       dn;
    logic [31:0]      mem [2][16];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hold = 0;
    bit rnd_en = 1'b0;
    int done_cnt [2];
    int viol [2];
    int addr_viol [2];
    int first_wr [2];
    int last_wr [2];
    int done_cyc [2];
    int busy_at_done [2];
    int cnt [2];
    logic [3:0] last_addr [2];
    logic [7:0] got_q [2][$];
    logic [7:0] exp_q [2][$];
    logic [3:0] addr_q [2][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rdd[0] <= mem[0][rda[0]];
        rdd[1] <= mem[1][rda[1]];
    end

    hex_dump_tx #(.NWORDS(NA), .WORD_W(32), .AW(4)) u_dut_a (
        .clk(clk), .rst(rst), .trigger(trigger), .rd_addr(rda[0]),
        .rd_data(rdd[0]), .tx_data(txd[0]), .tx_wr(txw[0]),
        .tx_busy(txb[0]), .busy(bsy[0]), .done(dn[0])
    );

    hex_dump_tx #(.NWORDS(NB), .WORD_W(32), .AW(4)) u_dut_b (
        .clk(clk), .rst(rst), .trigger(trigger), .rd_addr(rda[1]),
        .rd_data(rdd[1]), .tx_data(txd[1]), .tx_wr(txw[1]),
        .tx_busy(txb[1]), .busy(bsy[1]), .done(dn[1])
    );

    // Monitor plus UART model: busy rises right after a write strobe and
    // stays up for `hold` cycles; optional random extra busy cycles.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                cnt[g] = 0;
                txb[g] = 1'b0;
                last_addr[g] = '0;
            end else begin
                if (txw[g]) begin
                    got_q[g].push_back(txd[g]);
                    if (txb[g]) viol[g]++;
                    if (got_q[g].size() == 1) first_wr[g] = cyc;
                    last_wr[g] = cyc;
                end
                if (dn[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                    busy_at_done[g] = int'(bsy[g]);
                end
                if (rda[g] != last_addr[g]) begin
                    addr_q[g].push_back(rda[g]);
                    last_addr[g] = rda[g];
                end
                if (int'(rda[g]) >= ((g == 0) ? NA : NB)) addr_viol[g]++;
                if (txw[g] && hold > 0) cnt[g] = hold;
                else if (cnt[g] > 0) cnt[g]--;
                txb[g] = (cnt[g] > 0) || (rnd_en && $urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic cmp(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic build_exp(input int g, input int n);
        exp_q[g].delete();
        for (int w = 0; w < n; w++) begin
`ifdef HEX_DUMP_INDEX_EN
            exp_q[g].push_back(8'h52);
            exp_q[g].push_back(hexc(w));
            exp_q[g].push_back(8'h3D);
`endif
            for (int k = 7; k >= 0; k--)
                exp_q[g].push_back(hexc(int'((mem[g][w] >> (4 * k)) & 32'hF)));
            exp_q[g].push_back(8'h0D);
            exp_q[g].push_back(8'h0A);
        end
    endtask

    task automatic clr_mon();
        for (int g = 0; g < 2; g++) begin
            got_q[g].delete();
            addr_q[g].delete();
            done_cnt[g] = 0;
            viol[g] = 0;
            addr_viol[g] = 0;
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit);
        int n = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        cmp({nm, "/in_time"}, longint'(n < limit), 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_dump(input string nm);
        for (int g = 0; g < 2; g++) begin
            build_exp(g, (g == 0) ? NA : NB);
            cmp($sformatf("%s/g%0d/count", nm, g), got_q[g].size(), exp_q[g].size());
            for (int i = 0; i < got_q[g].size() && i < exp_q[g].size(); i++)
                cmp($sformatf("%s/g%0d/byte%0d", nm, g, i), got_q[g][i], exp_q[g][i]);
            cmp($sformatf("%s/g%0d/done_cnt", nm, g), done_cnt[g], 1);
            cmp($sformatf("%s/g%0d/busy_at_done", nm, g), busy_at_done[g], 0);
            cmp($sformatf("%s/g%0d/busy_after", nm, g), bsy[g], 0);
            cmp($sformatf("%s/g%0d/wr_while_busy", nm, g), viol[g], 0);
            cmp($sformatf("%s/g%0d/addr_range", nm, g), addr_viol[g], 0);
        end
    endtask

    task automatic run_dump(input string nm, input int limit);
        clr_mon();
        pulse_trigger();
        wait_done(nm, limit);
        check_dump(nm);
    endtask

    task automatic fill_random();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 16; i++) mem[g][i] = $urandom;
    endtask

    initial begin
        vec_t tbl [4];
        logic [7:0] line [$];
        int n;
        string nm;

        tbl[0].word0 = 32'h0000002A; tbl[0].word1 = 32'h00000000; tbl[0].text = "0000002A";
        tbl[1].word0 = 32'hDEADBEEF; tbl[1].word1 = 32'h01234567; tbl[1].text = "DEADBEEF";
        tbl[2].word0 = 32'hFFFFFFFF; tbl[2].word1 = 32'h89ABCDEF; tbl[2].text = "FFFFFFFF";
        tbl[3].word0 = 32'h01234567; tbl[3].word1 = 32'hFEDCBA98; tbl[3].text = "01234567";

        fill_random();
        clr_mon();
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            cmp($sformatf("reset/g%0d/rd_addr", g), rda[g], 0);
            cmp($sformatf("reset/g%0d/tx_data", g), txd[g], 0);
            cmp($sformatf("reset/g%0d/tx_wr", g), txw[g], 0);
            cmp($sformatf("reset/g%0d/busy", g), bsy[g], 0);
            cmp($sformatf("reset/g%0d/done", g), dn[g], 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table: A's single line against literal text, B against the model.
        for (int r = 0; r < 4; r++) begin
            nm = $sformatf("tbl%0d", r);
            mem[0][0] = tbl[r].word0;
            mem[1][0] = tbl[r].word0;
            mem[1][1] = tbl[r].word1;
            mem[1][2] = $urandom;
            mem[1][3] = $urandom;
            run_dump(nm, 1000);
            line.delete();
`ifdef HEX_DUMP_INDEX_EN
            line.push_back(8'h52); line.push_back(8'h30); line.push_back(8'h3D);
`endif
            for (int k = 0; k < 8; k++) line.push_back(tbl[r].text[63 - 8 * k -: 8]);
            line.push_back(8'h0D);
            line.push_back(8'h0A);
            cmp({nm, "/lit_count"}, got_q[0].size(), line.size());
            for (int i = 0; i < got_q[0].size() && i < line.size(); i++)
                cmp($sformatf("%s/lit%0d", nm, i), got_q[0][i], line[i]);
            cmp({nm, "/a_span"}, last_wr[0] - first_wr[0], 3 * (CH - 1));
            cmp({nm, "/a_done_lat"}, done_cyc[0] - last_wr[0], 3);
            cmp({nm, "/b_span"}, last_wr[1] - first_wr[1], (2 + 3 * CH) * (NB - 1) + 3 * (CH - 1));
            cmp({nm, "/b_done_lat"}, done_cyc[1] - last_wr[1], 3);
            cmp({nm, "/a_addr_moves"}, addr_q[0].size(), 0);
            cmp({nm, "/b_addr_moves"}, addr_q[1].size(), 4);
            for (int i = 0; i < 4 && i < addr_q[1].size(); i++)
                cmp($sformatf("%s/b_addr%0d", nm, i), addr_q[1][i], (i + 1) % 4);
        end

`ifdef HEX_DUMP_INDEX_EN
        begin
            logic [7:0] l2 [13];
            l2 = '{8'h52, 8'h31, 8'h3D, 8'h46, 8'h46, 8'h46, 8'h46,
                   8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
            mem[1][1] = 32'hFFFFFFFF;
            run_dump("idx_line2", 1000);
            for (int i = 0; i < 13; i++)
                if (got_q[1].size() > 13 + i)
                    cmp($sformatf("idx_line2/byte%0d", i), got_q[1][13 + i], l2[i]);
                else
                    cmp($sformatf("idx_line2/missing%0d", i), got_q[1].size(), 26 + i);
        end
`endif

        // Long UART busy after every byte.
        fill_random();
        hold = 50;
        run_dump("hold50", 8000);
        hold = 0;

        // Random busy patterns and data.
        for (int it = 0; it < 3; it++) begin
            fill_random();
            rnd_en = 1'b1;
            hold = $urandom_range(0, 4);
            run_dump($sformatf("rand%0d", it), 4000);
        end
        rnd_en = 1'b0;
        hold = 0;
        repeat (4) @(negedge clk);

        // Second trigger mid-dump is ignored.
        fill_random();
        clr_mon();
        pulse_trigger();
        repeat (20) @(negedge clk);
        pulse_trigger();
        wait_done("retrig", 1000);
        check_dump("retrig");

        // Reset right after the 4th byte, then a clean restart.
        fill_random();
        clr_mon();
        pulse_trigger();
        n = 0;
        while (got_q[1].size() < 4 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        cmp("rst_mid/in_time", longint'(n < 500), 1);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            cmp($sformatf("rst_mid/g%0d/tx_wr", g), txw[g], 0);
            cmp($sformatf("rst_mid/g%0d/busy", g), bsy[g], 0);
            cmp($sformatf("rst_mid/g%0d/rd_addr", g), rda[g], 0);
            cmp($sformatf("rst_mid/g%0d/bytes", g), got_q[g].size(), 4);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_dump("after_rst", 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
